// File: rtl/ram_arbiter.sv
// ram_arbiter
// Round-robin arbiter and sequencer that shares the single port of the
// 256x8 program/data RAM between two requesters. Port 0 is instruction fetch.
// Port 1 is load/store or the loader. Each accepted request becomes one
// registered RAM strobe. A read also returns a one-cycle valid pulse to the
// requesting port.
//
// Ports
//   clk                  system clock, rising edge
//   rst                  synchronous active-high reset
//   req0/req1            access request, held with its operands until gnt
//   we0/we1              1 = write, 0 = read
//   addr0/addr1          access address
//   wdata0/wdata1        write data (ignored for reads)
//   gnt0/gnt1            one-cycle pulse: request accepted
//   rvalid0/rvalid1      one-cycle pulse: rdata holds this port's read result
//   rdata                shared read data, wired straight from ram_out
//   busy                 high whenever the sequencer is not idle
//   ram_read/ram_write   registered RAM strobes
//   ram_addr/ram_data    registered RAM address / write data
//   ram_out              registered RAM output
module ram_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic              ram_read,
  output logic              ram_write,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_data,
  input  logic [DATA_W-1:0] ram_out
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic              last, last_nxt;  // port granted most recently
  logic              win, win_nxt;    // port currently being served
  logic              pick;            // arbitration result in IDLE
  logic              gnt0_nxt, gnt1_nxt;
  logic              rvalid0_nxt, rvalid1_nxt;
  logic              read_nxt, write_nxt;
  logic [ADDR_W-1:0] addr_nxt;
  logic [DATA_W-1:0] data_nxt;

  // A lone requester wins. On a tie, the port that was not granted last wins.
  assign pick  = (req0 & req1) ? ~last : req1;

  assign busy  = (state != IDLE);
  assign rdata = ram_out;

  // NOTE: every output of this block gets a default first. Then no path
  // leaves a signal unassigned, and no latch is inferred.
  always_comb begin
    state_nxt   = state;
    last_nxt    = last;
    win_nxt     = win;
    gnt0_nxt    = 1'b0;
    gnt1_nxt    = 1'b0;
    rvalid0_nxt = 1'b0;
    rvalid1_nxt = 1'b0;
    read_nxt    = 1'b0;
    write_nxt   = 1'b0;
    addr_nxt    = ram_addr;
    data_nxt    = ram_data;

    unique case (state)
      IDLE: begin
        if (req0 | req1) begin
          state_nxt = ACCESS;
          win_nxt   = pick;
          last_nxt  = pick;
          if (pick) begin
            gnt1_nxt  = 1'b1;
            write_nxt = we1;
            read_nxt  = ~we1;
            addr_nxt  = addr1;
            data_nxt  = wdata1;
          end else begin
            gnt0_nxt  = 1'b1;
            write_nxt = we0;
            read_nxt  = ~we0;
            addr_nxt  = addr0;
            data_nxt  = wdata0;
          end
        end
      end

      ACCESS: begin
        // Exactly one strobe is high here. A read waits one more cycle, because
        // the RAM captures its output on the edge that leaves ACCESS.
        if (ram_write) begin
          state_nxt = IDLE;
        end else begin
          state_nxt   = RESP;
          rvalid0_nxt = ~win;
          rvalid1_nxt = win;
        end
      end

      RESP: state_nxt = IDLE;

      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      last      <= 1'b1;
      win       <= 1'b0;
      gnt0      <= 1'b0;
      gnt1      <= 1'b0;
      rvalid0   <= 1'b0;
      rvalid1   <= 1'b0;
      ram_read  <= 1'b0;
      ram_write <= 1'b0;
      ram_addr  <= '0;
      ram_data  <= '0;
    end else begin
      state     <= state_nxt;
      last      <= last_nxt;
      win       <= win_nxt;
      gnt0      <= gnt0_nxt;
      gnt1      <= gnt1_nxt;
      rvalid0   <= rvalid0_nxt;
      rvalid1   <= rvalid1_nxt;
      ram_read  <= read_nxt;
      ram_write <= write_nxt;
      ram_addr  <= addr_nxt;
      ram_data  <= data_nxt;
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter
// Bench for ram_arbiter. A behavioural 256x8 RAM with a registered output sits
// on the RAM side of the design. A transaction-level model predicts every
// output on every cycle. The model tracks each access as an age since its
// grant, compared with an occupancy of 2 cycles for a write and 3 for a read.
// Directed scenarios log grants and read returns, and literal expectations
// pin the model down.
module tb_ram_arbiter;

  localparam int AW = 8;
  localparam int DW = 8;

  logic          clk    = 1'b0;
  logic          rst    = 1'b1;
  logic          req0   = 1'b0;
  logic          req1   = 1'b0;
  logic          we0    = 1'b0;
  logic          we1    = 1'b0;
  logic [AW-1:0] addr0  = '0;
  logic [AW-1:0] addr1  = '0;
  logic [DW-1:0] wdata0 = '0;
  logic [DW-1:0] wdata1 = '0;
  logic          gnt0, gnt1, rvalid0, rvalid1, busy, ram_read, ram_write;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_data, rdata, ram_out;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ram_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk      (clk),
    .rst      (rst),
    .req0     (req0),
    .req1     (req1),
    .we0      (we0),
    .we1      (we1),
    .addr0    (addr0),
    .addr1    (addr1),
    .wdata0   (wdata0),
    .wdata1   (wdata1),
    .gnt0     (gnt0),
    .gnt1     (gnt1),
    .rvalid0  (rvalid0),
    .rvalid1  (rvalid1),
    .rdata    (rdata),
    .busy     (busy),
    .ram_read (ram_read),
    .ram_write(ram_write),
    .ram_addr (ram_addr),
    .ram_data (ram_data),
    .ram_out  (ram_out)
  );

  // Behavioural RAM. It is cleared by the same reset.
  logic [DW-1:0] ram_mem [2**AW];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 2**AW; i++) ram_mem[i] <= '0;
      ram_out <= '0;
    end else begin
      if (ram_write) ram_mem[ram_addr] <= ram_data;
      if (ram_read)  ram_out <= ram_mem[ram_addr];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- model ----------------
  int            m_age  = 0;     // cycles since grant of the active access, 0 = none
  int            m_len  = 2;     // occupancy of the active access in cycles
  logic          m_port = 1'b0;
  logic          m_we   = 1'b0;
  logic          m_last = 1'b1;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_data = '0;
  logic [DW-1:0] m_rd   = '0;
  logic [DW-1:0] m_mem [2**AW];

  // Event logs for the directed checks.
  int            cyc = 0;
  int            gnt_q[$];
  logic [DW-1:0] rv0_q[$];
  logic [DW-1:0] rv1_q[$];
  int            gnt1_cyc = 0;
  int            rv1_cyc  = 0;
  int            wr_cnt   = 0;

  always @(posedge clk) begin
    logic [6:0] exp_ctl;
    logic [6:0] act_ctl;
    cyc++;
    if (rst) begin
      m_age  = 0;
      m_last = 1'b1;
      m_addr = '0;
      m_data = '0;
      for (int i = 0; i < 2**AW; i++) m_mem[i] = '0;
    end else if (m_age != 0) begin
      m_age++;
      if (m_age >= m_len) m_age = 0;
    end else if (req0 || req1) begin
      m_port = (req0 && req1) ? ~m_last : req1;
      m_last = m_port;
      m_we   = m_port ? we1 : we0;
      m_addr = m_port ? addr1 : addr0;
      m_data = m_port ? wdata1 : wdata0;
      m_len  = m_we ? 2 : 3;
      m_age  = 1;
      // Accesses take effect in grant order.
      if (m_we) m_mem[m_addr] = m_data;
      else      m_rd = m_mem[m_addr];
    end

    #1;
    exp_ctl = {m_age == 1 && !m_port,
               m_age == 1 &&  m_port,
               m_age == 2 && !m_we && !m_port,
               m_age == 2 && !m_we &&  m_port,
               m_age != 0,
               m_age == 1 && !m_we,
               m_age == 1 &&  m_we};
    act_ctl = {gnt0, gnt1, rvalid0, rvalid1, busy, ram_read, ram_write};
    check("ctl{g0,g1,rv0,rv1,busy,rd,wr}", 32'(act_ctl), 32'(exp_ctl));
    check("ram_addr", 32'(ram_addr), 32'(m_addr));
    check("ram_data", 32'(ram_data), 32'(m_data));
    check("rdata_wire", 32'(rdata), 32'(ram_out));
    if (exp_ctl[4] || exp_ctl[3]) check("rdata", 32'(rdata), 32'(m_rd));

    if (gnt0) gnt_q.push_back(0);
    if (gnt1) begin gnt_q.push_back(1); gnt1_cyc = cyc; end
    if (rvalid0) rv0_q.push_back(rdata);
    if (rvalid1) begin rv1_q.push_back(rdata); rv1_cyc = cyc; end
    if (ram_write) wr_cnt++;
  end

  // ---------------- stimulus ----------------
  task automatic drive(input int p, input logic r, input logic w,
                       input logic [AW-1:0] a, input logic [DW-1:0] d);
    if (p == 0) begin req0 = r; we0 = w; addr0 = a; wdata0 = d; end
    else        begin req1 = r; we1 = w; addr1 = a; wdata1 = d; end
  endtask

  // Hold a request until it has been granted n times, then drop it in the
  // cycle of the last grant.
  task automatic port_stream(input int p, input logic w, input logic [AW-1:0] a,
                             input logic [DW-1:0] d, input int n);
    int got = 0;
    int waited = 0;
    @(negedge clk);
    drive(p, 1'b1, w, a, d);
    while (got < n && waited < 100) begin
      @(posedge clk);
      #2;
      waited++;
      if ((p == 0 && gnt0) || (p == 1 && gnt1)) got++;
    end
    check(p == 0 ? "gnt_count0" : "gnt_count1", 32'(got), 32'(n));
    @(negedge clk);
    drive(p, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_logs();
    gnt_q.delete();
    rv0_q.delete();
    rv1_q.delete();
  endtask

  initial begin
    int exp_g[4];
    int waited;
    logic seen;

    // Reset, then 3 idle cycles.
    idle(2);
    rst = 1'b0;
    idle(3);
    check("idle_ctl", 32'({gnt0, gnt1, rvalid0, rvalid1, busy, ram_read, ram_write}), 32'd0);
    check("idle_addr", 32'(ram_addr), 32'h00);
    check("idle_data", 32'(ram_data), 32'h00);

    // Port 1 writes 0x5A to 0x10 and then reads it back.
    clear_logs();
    wr_cnt = 0;
    port_stream(1, 1'b1, 8'h10, 8'h5A, 1);
    idle(3);
    check("wr_strobe_cycles", 32'(wr_cnt), 32'd1);
    port_stream(1, 1'b0, 8'h10, 8'h00, 1);
    idle(3);
    check("rd_rvalid_count", 32'(rv1_q.size()), 32'd1);
    check("rd_5a", 32'(rv1_q.size() > 0 ? rv1_q[0] : 8'h00), 32'h5A);
    check("rd_latency", 32'(rv1_cyc - gnt1_cyc), 32'd1);

    // Preload 0x11 at 0x01 and 0x22 at 0x02. Port 1 goes last, so port 0 wins the next tie.
    port_stream(0, 1'b1, 8'h01, 8'h11, 1);
    port_stream(1, 1'b1, 8'h02, 8'h22, 1);
    idle(3);

    // Both ports read continuously: the grants must alternate.
    clear_logs();
    fork
      port_stream(0, 1'b0, 8'h01, 8'h00, 2);
      port_stream(1, 1'b0, 8'h02, 8'h00, 2);
    join
    idle(4);
    exp_g = '{0, 1, 0, 1};
    check("rr_grants", 32'(gnt_q.size()), 32'd4);
    for (int i = 0; i < 4; i++)
      check("rr_order", (i < gnt_q.size()) ? 32'(gnt_q[i]) : 32'hFFFF_FFFF, 32'(exp_g[i]));
    check("rr_rv0_count", 32'(rv0_q.size()), 32'd2);
    check("rr_rv1_count", 32'(rv1_q.size()), 32'd2);
    check("rr_rv0_data", 32'(rv0_q.size() > 0 ? rv0_q[0] : 8'h00), 32'h11);
    check("rr_rv1_data", 32'(rv1_q.size() > 0 ? rv1_q[0] : 8'h00), 32'h22);

    // Tie: port 0 writes 0xC3 to 0x20 and wins, then port 1 reads the new value.
    clear_logs();
    fork
      port_stream(0, 1'b1, 8'h20, 8'hC3, 1);
      port_stream(1, 1'b0, 8'h20, 8'h00, 1);
    join
    idle(4);
    check("wr_rd_first", 32'(gnt_q.size() > 0 ? gnt_q[0] : -1), 32'd0);
    check("wr_rd_data", 32'(rv1_q.size() > 0 ? rv1_q[0] : 8'h00), 32'hC3);

    // Port 0 drops req in its grant cycle while port 1 keeps requesting.
    clear_logs();
    fork
      port_stream(0, 1'b0, 8'h01, 8'h00, 1);
      port_stream(1, 1'b0, 8'h02, 8'h00, 1);
    join
    idle(6);
    check("drop_grants", 32'(gnt_q.size()), 32'd2);
    check("drop_first", 32'(gnt_q.size() > 0 ? gnt_q[0] : -1), 32'd0);
    check("drop_second", 32'(gnt_q.size() > 1 ? gnt_q[1] : -1), 32'd1);

    // Reset lands on the edge that would start the read response.
    clear_logs();
    @(negedge clk);
    drive(1, 1'b1, 1'b0, 8'h10, 8'h00);
    waited = 0;
    seen = 1'b0;
    while (!seen && waited < 50) begin
      @(posedge clk);
      #2;
      waited++;
      if (gnt1) seen = 1'b1;
    end
    check("rst_gnt_seen", 32'(seen), 32'd1);
    @(negedge clk);
    drive(1, 1'b0, 1'b0, '0, '0);
    rst = 1'b1;
    @(posedge clk);
    #2;
    check("rst_strobes", 32'({busy, ram_read, ram_write, rvalid0, rvalid1}), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    idle(3);
    check("rst_no_rvalid", 32'(rv1_q.size() + rv0_q.size()), 32'd0);

    // First tie after reset goes to port 0.
    clear_logs();
    fork
      port_stream(0, 1'b0, 8'h05, 8'h00, 1);
      port_stream(1, 1'b0, 8'h06, 8'h00, 1);
    join
    idle(4);
    check("rst_tie_first", 32'(gnt_q.size() > 0 ? gnt_q[0] : -1), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
